// File: rtl/cnn_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_accum_pkg
// Description : Shared types and defaults for the CNN convolution accumulator:
//               FSM state encoding, default widths and a clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int c_def_prod_width = 15;
    localparam int c_def_bias_width = 16;
    localparam int c_def_acc_width  = 24;
    localparam int c_def_out_width  = 16;
    localparam int c_def_klen       = 9;
    localparam int c_def_shift      = 4;
    localparam int c_cnt_width      = 8;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_accum_sat.sv
`default_nettype none
// ============================================================================
// Module      : cnn_accum_sat
// Description : Combinational output stage: arithmetic right shift, optional
//               ReLU, then signed saturation to the output width.
//               ReLU is enabled by defining CNN_CONV_ACCUM_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_accum_sat #(
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 4
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [OUT_WIDTH-1:0] res
);

    // Clamp bounds expressed at accumulator width.
    localparam logic [ACC_WIDTH-1:0] c_sat_max =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_sat_min =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic signed [ACC_WIDTH-1:0] w_act;

    generate
        if (ACC_WIDTH < OUT_WIDTH) begin : g_bad_width
            $error("cnn_accum_sat: ACC_WIDTH must be >= OUT_WIDTH");
        end
    endgenerate

    assign w_shifted = $signed(acc) >>> SHIFT;

`ifdef CNN_CONV_ACCUM_RELU_EN
    assign w_act = w_shifted[ACC_WIDTH-1] ? '0 : w_shifted;
`else
    assign w_act = w_shifted;
`endif

    // Saturate the activated value into the signed output range.
    always_comb begin
        res = w_act[OUT_WIDTH-1:0];
        if (w_act > $signed(c_sat_max)) begin
            res = c_sat_max[OUT_WIDTH-1:0];
        end else if (w_act < $signed(c_sat_min)) begin
            res = c_sat_min[OUT_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnn_conv_accum.sv
`default_nettype none
// ============================================================================
// Module      : cnn_conv_accum
// Description : Accumulates KLEN unsigned products plus a signed bias per
//               window and emits one shifted, saturated result per window
//               over a valid/ready stream. Optional ReLU on the result is
//               enabled by defining CNN_CONV_ACCUM_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_conv_accum
    import cnn_accum_pkg::*;
#(
    parameter int PROD_WIDTH = c_def_prod_width,
    parameter int BIAS_WIDTH = c_def_bias_width,
    parameter int ACC_WIDTH  = c_def_acc_width,
    parameter int OUT_WIDTH  = c_def_out_width,
    parameter int KLEN       = c_def_klen,
    parameter int SHIFT      = c_def_shift
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    input  logic [BIAS_WIDTH-1:0] bias,
    output logic [OUT_WIDTH-1:0]  out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  busy
);

    localparam int c_grow    = PROD_WIDTH + clog2(KLEN);
    localparam int c_acc_min = ((c_grow > BIAS_WIDTH) ? c_grow : BIAS_WIDTH) + 2;
    localparam logic [c_cnt_width-1:0] c_last_cnt = c_cnt_width'(KLEN - 1);

    generate
        if (ACC_WIDTH < c_acc_min) begin : g_chk_acc
            $error("cnn_conv_accum: ACC_WIDTH too small, accumulator could wrap");
        end
        if (KLEN < 1 || KLEN > 255) begin : g_chk_klen
            $error("cnn_conv_accum: KLEN must be in 1..255");
        end
        if (SHIFT < 0 || SHIFT >= ACC_WIDTH) begin : g_chk_shift
            $error("cnn_conv_accum: SHIFT must be in 0..ACC_WIDTH-1");
        end
    endgenerate

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_run;
    logic [c_cnt_width-1:0]  r_cnt;
    logic [ACC_WIDTH-1:0]    r_acc;
    logic                    w_beat;
    logic [ACC_WIDTH-1:0]    w_prod_ext;
    logic [ACC_WIDTH-1:0]    w_bias_ext;

    assign w_beat     = prod_tvalid & prod_tready;
    assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, prod_tdata};
    assign w_bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holds prod_tready low until the first clock edge after reset release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        prod_tready = 1'b0;
        out_tvalid  = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                prod_tready = r_run;
                if (prod_tvalid && r_run) begin
                    w_state_nxt = (KLEN == 1) ? OUT : ACCUM;
                end
            end
            ACCUM: begin
                prod_tready = r_run;
                busy        = 1'b1;
                if (prod_tvalid && r_run && (r_cnt == c_last_cnt)) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                out_tvalid = 1'b1;
                busy       = 1'b1;
                if (out_tready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and beat counter; the first beat of a window loads the bias.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_beat) begin
            if (r_state == IDLE) begin
                r_acc <= w_bias_ext + w_prod_ext;
                r_cnt <= c_cnt_width'(1);
            end else begin
                r_acc <= r_acc + w_prod_ext;
                r_cnt <= r_cnt + c_cnt_width'(1);
            end
        end
    end

    // The accumulator is frozen in OUT, so the result is stable under backpressure.
    cnn_accum_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_sat (
        .acc (r_acc),
        .res (out_tdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_cnn_conv_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_conv_accum
// Description : Self-checking bench for cnn_conv_accum. Two instances
//               (SHIFT=0 and SHIFT=4) share one input stream; results are
//               compared against an arithmetic reference model. Honours
//               CNN_CONV_ACCUM_RELU_EN in the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_conv_accum;

    localparam int KLEN = 9;

    logic        clk;
    logic        rst_n;
    logic [14:0] prod_tdata;
    logic        prod_tvalid;
    logic [15:0] bias;
    logic        out_tready;

    logic        tready0, tready4;
    logic        tvalid0, tvalid4;
    logic        busy0, busy4;
    logic [15:0] tdata0, tdata4;

    int total  = 0;
    int bad    = 0;
    int hs_seen = 0;
    int hs_exp  = 0;
    int unsigned prods[KLEN];

    cnn_conv_accum #(
        .PROD_WIDTH (15), .BIAS_WIDTH (16), .ACC_WIDTH (24),
        .OUT_WIDTH (16), .KLEN (KLEN), .SHIFT (0)
    ) dut0 (
        .ap_clk (clk), .ap_rst_n (rst_n),
        .prod_tdata (prod_tdata), .prod_tvalid (prod_tvalid), .prod_tready (tready0),
        .bias (bias),
        .out_tdata (tdata0), .out_tvalid (tvalid0), .out_tready (out_tready),
        .busy (busy0)
    );

    cnn_conv_accum #(
        .PROD_WIDTH (15), .BIAS_WIDTH (16), .ACC_WIDTH (24),
        .OUT_WIDTH (16), .KLEN (KLEN), .SHIFT (4)
    ) dut4 (
        .ap_clk (clk), .ap_rst_n (rst_n),
        .prod_tdata (prod_tdata), .prod_tvalid (prod_tvalid), .prod_tready (tready4),
        .bias (bias),
        .out_tdata (tdata4), .out_tvalid (tvalid4), .out_tready (out_tready),
        .busy (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every output handshake actually performed by the SHIFT=0 instance.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && tvalid0 === 1'b1 && out_tready === 1'b1) begin
            hs_seen++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Expected output: floor shift, optional ReLU, clamp to 16-bit signed.
    function automatic longint model(input longint s, input int sh);
        longint v;
        v = s >>> sh;
`ifdef CNN_CONV_ACCUM_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int unsigned v);
        for (int i = 0; i < KLEN; i++) prods[i] = v;
    endtask

    task automatic reset_pulse();
        prod_tvalid = 1'b0;
        out_tready  = 1'b0;
        rst_n       = 1'b0;
        step();
        chk("rst_prod_tready0", tready0, 0);
        chk("rst_prod_tready4", tready4, 0);
        chk("rst_out_tvalid0", tvalid0, 0);
        chk("rst_out_tvalid4", tvalid4, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_out_tdata0", tdata0, 0);
        chk("rst_out_tdata4", tdata4, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", tready0, 0);
        step();
        chk("ready_after_release0", tready0, 1);
        chk("ready_after_release4", tready4, 1);
        chk("no_valid_after_release", tvalid0, 0);
    endtask

    // One full window; abort=1 resets while the result is pending instead of consuming it.
    task automatic run_window(input longint b, input int gap_max, input int stall,
                              input bit jitter, input bit abort);
        longint sum;
        int     g;
        sum = b;
        for (int i = 0; i < KLEN; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int k = 0; k < g; k++) begin
                prod_tvalid = 1'b0;
                prod_tdata  = 15'($urandom);
                out_tready  = 1'($urandom);
                if (jitter) bias = 16'($urandom);
                step();
                chk("gap_no_valid", tvalid0, 0);
                chk("gap_ready", tready0, 1);
            end
            prod_tvalid = 1'b1;
            prod_tdata  = 15'(prods[i]);
            out_tready  = 1'($urandom);
            bias        = (i == 0 || !jitter) ? 16'(b) : 16'($urandom);
            chk("ready_before_beat", tready0, 1);
            step();
            sum += longint'(prods[i]);
            if (i < KLEN - 1) begin
                chk("accum_no_valid", tvalid0, 0);
                chk("accum_busy", busy0, 1);
            end
        end
        // Keep offering products while the result waits; none may be taken.
        prod_tvalid = 1'b1;
        prod_tdata  = 15'($urandom);
        bias        = 16'($urandom);
        out_tready  = 1'b0;
        chk("latency_valid0", tvalid0, 1);
        chk("latency_valid4", tvalid4, 1);
        chk("out_prod_tready", tready0, 0);
        chk("out_busy", busy0, 1);
        chk("data_shift0", $signed(tdata0), model(sum, 0));
        chk("data_shift4", $signed(tdata4), model(sum, 4));
        for (int s = 0; s < stall; s++) begin
            prod_tdata = 15'($urandom);
            step();
            chk("stall_valid", tvalid0, 1);
            chk("stall_prod_tready", tready0, 0);
            chk("stall_data0", $signed(tdata0), model(sum, 0));
            chk("stall_data4", $signed(tdata4), model(sum, 4));
        end
        if (abort) begin
            reset_pulse();
        end else begin
            out_tready = 1'b1;
            step();
            hs_exp++;
            out_tready  = 1'b0;
            prod_tvalid = 1'b0;
            chk("post_hs_valid0", tvalid0, 0);
            chk("post_hs_valid4", tvalid4, 0);
            chk("post_hs_ready", tready0, 1);
            chk("post_hs_busy", busy0, 0);
        end
        prod_tvalid = 1'b0;
    endtask

    initial begin
        logic signed [15:0] bs;
        rst_n       = 1'b0;
        prod_tvalid = 1'b0;
        prod_tdata  = '0;
        bias        = '0;
        out_tready  = 1'b0;

        reset_pulse();
        chk("idle_busy", busy0, 0);

        // Nine products of 100, no bias: 900 unshifted, 56 with SHIFT=4.
        fill(100);
        run_window(0, 0, 0, 0, 0);

        // Negative total: -100 plain, 0 with ReLU.
        fill(100);
        run_window(-1000, 0, 0, 0, 0);

        // Positive saturation.
        fill(32767);
        run_window(0, 0, 0, 0, 0);

        // Most negative bias, zero products.
        fill(0);
        run_window(-32768, 0, 0, 0, 0);

        // Backpressure for five cycles in OUT.
        fill(100);
        run_window(0, 0, 5, 0, 0);

        // Random windows with gaps, stalls and mid-window bias changes.
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < KLEN; i++) prods[i] = $urandom_range(0, 32767);
            bs = 16'($urandom);
            run_window(longint'(bs), 3, int'($urandom_range(0, 3)), 1, 0);
        end

        // Reset after four beats discards the partial window.
        for (int i = 0; i < 4; i++) begin
            prod_tvalid = 1'b1;
            prod_tdata  = 15'($urandom);
            bias        = 16'($urandom);
            step();
        end
        reset_pulse();
        chk("abort_no_handshake", hs_seen, hs_exp);
        fill(10);
        run_window(5, 0, 0, 0, 0);

        // Reset while the result is pending discards it.
        for (int i = 0; i < KLEN; i++) prods[i] = $urandom_range(0, 32767);
        run_window(123, 0, 2, 0, 1);
        chk("abort_out_no_handshake", hs_seen, hs_exp);

        fill(200);
        run_window(-3, 1, 1, 1, 0);

        chk("handshake_count", hs_seen, hs_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
